// File: rtl/lsu_bus_bridge.sv
// ---------------------------------------------------------------------------
// lsu_bus_bridge
//   Load/store unit that sits between the CPU memory-access stage and a
//   variable-latency data bus. It holds the pipeline with o_busy while a bus
//   access is outstanding. It steers store bytes onto the correct lanes and
//   sign- or zero-extends load data. It reports misalignment, timeout and bus
//   error faults.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge) / asynchronous active-low reset
//   i_clk_ce              pipeline clock enable, only used to leave DONE
//   i_req_rd, i_req_wr    load / store request levels from the MA stage
//   i_addr, i_wdata       byte address, LSB-aligned store data
//   i_funct3              [1:0] size (00 B, 01 H, 1x W), [2] zero-extend load
//   o_busy                stall request towards the pipeline clock enable
//   o_rdata               extended load result (held after DONE)
//   o_fault, o_fault_code 01 misaligned, 10 timeout, 11 bus error
//   o_bus_*               bus request: valid, word address, read strobe,
//                         byte write enables, lane-replicated write data
//   i_bus_ready/rdata/err bus completion, sampled when valid && ready
//   o_dbg_state           current FSM state (0 IDLE, 1 REQ, 2 DONE)
//
// Bus handshake: a request is presented with o_bus_valid=1 and all other
// o_bus_* outputs held stable until the cycle in which i_bus_ready=1. That
// cycle both accepts and completes the access, and i_bus_rdata/i_bus_err are
// sampled on that edge. If i_bus_ready never rises, valid is withdrawn after
// TIMEOUT cycles (never, when TIMEOUT is 0).
// ---------------------------------------------------------------------------
module lsu_bus_bridge #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT     = 255,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clk_ce,
   input  logic              i_req_rd,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   input  logic [2:0]        i_funct3,
   output logic              o_busy,
   output logic [31:0]       o_rdata,
   output logic              o_fault,
   output logic [1:0]        o_fault_code,
   output logic              o_bus_valid,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic              o_bus_rd,
   output logic [3:0]        o_bus_we,
   output logic [31:0]       o_bus_wdata,
   input  logic              i_bus_ready,
   input  logic [31:0]       i_bus_rdata,
   input  logic              i_bus_err,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam bit TO_EN = (TIMEOUT != 0);

   state_t state, state_nxt;

   // ---------------- request decode (IDLE inputs) ----------------
   logic        req_any;
   logic        is_b, is_h, is_w;
   logic [1:0]  lane;
   logic        misaligned;
   logic [3:0]  we_pat, we_lane;
   logic [31:0] wdata_lane;

   assign req_any = i_req_rd | i_req_wr;
   assign lane    = i_addr[1:0];
   assign is_b    = (i_funct3[1:0] == 2'b00);
   assign is_h    = (i_funct3[1:0] == 2'b01);
   assign is_w    = i_funct3[1];          // size 11 behaves as a word

   assign misaligned = ALIGN_CHECK && ((is_h && lane[0]) || (is_w && (lane != 2'b00)));

   // Shifting the pattern by the lane drops bits past byte 3, which is the
   // intended behaviour for misaligned accesses when the check is disabled.
   assign we_pat     = is_b ? 4'b0001 : (is_h ? 4'b0011 : 4'b1111);
   assign we_lane    = we_pat << lane;
   assign wdata_lane = is_b ? {4{i_wdata[7:0]}} :
                       (is_h ? {2{i_wdata[15:0]}} : i_wdata);

   // ---------------- registered access attributes ----------------
   logic        ld_b, ld_h, ld_uns, is_store;
   logic [1:0]  ld_shift;
   logic [31:0] cnt;
   logic        timeout_hit;
   logic [31:0] rword_sh, ld_ext;

   // The counter holds the number of REQ cycles already completed. So the
   // last permitted cycle is the one where it equals TIMEOUT-1.
   assign timeout_hit = TO_EN && (cnt == 32'(TIMEOUT - 1));

   assign rword_sh = i_bus_rdata >> {ld_shift, 3'b000};
   always_comb begin
      ld_ext = rword_sh;
      if (ld_b)
         ld_ext = ld_uns ? {24'h0, rword_sh[7:0]} : {{24{rword_sh[7]}}, rword_sh[7:0]};
      else if (ld_h)
         ld_ext = ld_uns ? {16'h0, rword_sh[15:0]} : {{16{rword_sh[15]}}, rword_sh[15:0]};
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_any) state_nxt = misaligned ? ST_DONE : ST_REQ;
         ST_REQ:  if (i_bus_ready || timeout_hit) state_nxt = ST_DONE;
         // Waiting for the pipeline to advance keeps a held request from
         // being issued a second time.
         ST_DONE: if (i_clk_ce) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // The reset term stops a request that is held high from showing busy
   // while reset is asserted.
   always_comb begin
      o_busy      = 1'b0;
      o_bus_valid = 1'b0;
      case (state)
         ST_IDLE: o_busy = i_rst_n & req_any;
         ST_REQ: begin
            o_busy      = i_rst_n;
            o_bus_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_dbg_state = state;

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rdata      <= '0;
         o_fault      <= 1'b0;
         o_fault_code <= 2'b00;
         o_bus_addr   <= '0;
         o_bus_rd     <= 1'b0;
         o_bus_we     <= 4'b0000;
         o_bus_wdata  <= '0;
         ld_b         <= 1'b0;
         ld_h         <= 1'b0;
         ld_uns       <= 1'b0;
         ld_shift     <= 2'b00;
         is_store     <= 1'b0;
         cnt          <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  if (misaligned) begin
                     o_fault      <= 1'b1;
                     o_fault_code <= 2'b01;
                  end else begin
                     // A store takes priority when both requests are set.
                     o_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                     o_bus_rd    <= ~i_req_wr;
                     o_bus_we    <= i_req_wr ? we_lane : 4'b0000;
                     o_bus_wdata <= i_req_wr ? wdata_lane : 32'h0;
                     ld_b        <= is_b;
                     ld_h        <= is_h;
                     ld_uns      <= i_funct3[2];
                     ld_shift    <= lane;
                     is_store    <= i_req_wr;
                     cnt         <= '0;
                  end
               end
            end
            ST_REQ: begin
               cnt <= cnt + 32'd1;
               if (i_bus_ready || timeout_hit) begin
                  o_bus_addr  <= '0;
                  o_bus_rd    <= 1'b0;
                  o_bus_we    <= 4'b0000;
                  o_bus_wdata <= '0;
               end
               if (i_bus_ready) begin
                  if (!is_store) o_rdata <= ld_ext;
                  o_fault      <= i_bus_err;
                  o_fault_code <= i_bus_err ? 2'b11 : 2'b00;
               end else if (timeout_hit) begin
                  o_rdata      <= '0;
                  o_fault      <= 1'b1;
                  o_fault_code <= 2'b10;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
